// File: rtl/axil_write_firewall.sv
// AXI4-Lite write firewall: holds one write at a time, blocks writes that land in an
// enabled protected region (SLVERR + violation log), forwards everything else downstream.
`timescale 1ns/1ps

module axil_write_firewall #(
   parameter int                      ADDR_W = 32,
   parameter int                      N_REG  = 4,
   parameter logic [N_REG*ADDR_W-1:0] REG_LO = {N_REG{32'h4000_0000}},
   parameter logic [N_REG*ADDR_W-1:0] REG_HI = {N_REG{32'h4000_FFFF}},
   parameter int                      CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // upstream
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_wvalid,
   output logic              s_wready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   output logic              s_bvalid,
   input  logic              s_bready,
   output logic [1:0]        s_bresp,
   // downstream
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_wstrb,
   input  logic              m_bvalid,
   output logic              m_bready,
   input  logic [1:0]        m_bresp,
   // protection control and status
   input  logic [N_REG-1:0]  region_en,
   input  logic              viol_clr,
   output logic              violation,
   output logic [ADDR_W-1:0] viol_addr,
   output logic [CNT_W-1:0]  viol_count
);

   typedef enum logic [2:0] {IDLE, CHECK, FWD, WAIT_B, RESP} state_t;

   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t              state, state_nxt;
   logic                aw_have, w_have;
   logic                aw_pend, w_pend;
   logic                blocked;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         data_q;
   logic [3:0]          strb_q;
   logic [1:0]          bresp_q;
   logic [ADDR_W-1:0]   viol_addr_q;
   logic [CNT_W-1:0]    viol_count_q;
   logic [CNT_W-1:0]    count_inc;

   // Region match on the captured address; only consumed while in CHECK.
   always_comb begin
      blocked = 1'b0;
      for (int i = 0; i < N_REG; i++) begin
         if (region_en[i] &&
             addr_q >= REG_LO[i*ADDR_W +: ADDR_W] &&
             addr_q <= REG_HI[i*ADDR_W +: ADDR_W])
            blocked = 1'b1;
      end
   end

   // NOTE: every output and next-state is given a default before the case so no
   // path through this block leaves a value unassigned and a latch is inferred.
   always_comb begin
      state_nxt = state;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      s_bvalid  = 1'b0;
      violation = 1'b0;
      case (state)
         IDLE: begin
            s_awready = !aw_have;
            s_wready  = !w_have;
            if (aw_have && w_have) state_nxt = CHECK;
         end
         CHECK: begin
            violation = blocked;
            state_nxt = blocked ? RESP : FWD;
         end
         FWD: begin
            m_awvalid = aw_pend;
            m_wvalid  = w_pend;
            if ((!aw_pend || m_awready) && (!w_pend || m_wready)) state_nxt = WAIT_B;
         end
         WAIT_B: begin
            m_bready = 1'b1;
            if (m_bvalid) state_nxt = RESP;
         end
         RESP: begin
            s_bvalid = 1'b1;
            if (s_bready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign count_inc = (&viol_count_q) ? viol_count_q : viol_count_q + CNT_W'(1);

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         aw_have      <= 1'b0;
         w_have       <= 1'b0;
         aw_pend      <= 1'b0;
         w_pend       <= 1'b0;
         bresp_q      <= 2'b00;
         viol_addr_q  <= '0;
         viol_count_q <= '0;
      end else begin
         state <= state_nxt;

         if (s_awvalid && s_awready) aw_have <= 1'b1;
         if (s_wvalid && s_wready)   w_have  <= 1'b1;
         if (state == RESP && s_bready) begin
            aw_have <= 1'b0;
            w_have  <= 1'b0;
         end

         if (state == CHECK && !blocked) begin
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
         end
         if (m_awvalid && m_awready) aw_pend <= 1'b0;
         if (m_wvalid && m_wready)   w_pend  <= 1'b0;

         if (state == CHECK && blocked)  bresp_q <= RESP_SLVERR;
         if (state == WAIT_B && m_bvalid) bresp_q <= m_bresp;

         // A block in the same cycle as a clear wins: the log restarts at this write.
         if (state == CHECK && blocked) begin
            viol_addr_q  <= addr_q;
            viol_count_q <= viol_clr ? CNT_W'(1) : count_inc;
         end else if (viol_clr) begin
            viol_addr_q  <= '0;
            viol_count_q <= '0;
         end
      end
   end

   // NOTE: the payload registers carry no reset; they are only observed behind
   // the captured/valid flags, which are reset.
   always_ff @(posedge clk) begin
      if (s_awvalid && s_awready) addr_q <= s_awaddr;
      if (s_wvalid && s_wready) begin
         data_q <= s_wdata;
         strb_q <= s_wstrb;
      end
   end

   assign m_awaddr   = addr_q;
   assign m_wdata    = data_q;
   assign m_wstrb    = strb_q;
   assign s_bresp    = bresp_q;
   assign viol_addr  = viol_addr_q;
   assign viol_count = viol_count_q;

endmodule

// File: tb/tb_axil_write_firewall.sv
// Directed bench for axil_write_firewall: acts as upstream master and downstream slave,
// with a second instance (CNT_W=2) sharing the stimulus to exercise counter saturation.
`timescale 1ns/1ps

module tb_axil_write_firewall;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_awvalid, s_wvalid, s_bready;
   logic [31:0] s_awaddr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        m_awready, m_wready, m_bvalid;
   logic [1:0]  m_bresp;
   logic [3:0]  region_en;
   logic        viol_clr;

   logic        s_awready, s_wready, s_bvalid;
   logic [1:0]  s_bresp;
   logic        m_awvalid, m_wvalid, m_bready;
   logic [31:0] m_awaddr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        violation;
   logic [31:0] viol_addr;
   logic [15:0] viol_count;

   logic        s_awready2, s_wready2, s_bvalid2;
   logic [1:0]  s_bresp2;
   logic        m_awvalid2, m_wvalid2, m_bready2;
   logic [31:0] m_awaddr2, m_wdata2;
   logic [3:0]  m_wstrb2;
   logic        violation2;
   logic [31:0] viol_addr2;
   logic [1:0]  viol_count2;

   always #5 clk = ~clk;

   axil_write_firewall dut (
      .clk(clk), .rst_n(rst_n),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .region_en(region_en), .viol_clr(viol_clr), .violation(violation),
      .viol_addr(viol_addr), .viol_count(viol_count)
   );

   axil_write_firewall #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .s_awvalid(s_awvalid), .s_awready(s_awready2), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready2), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid2), .s_bready(s_bready), .s_bresp(s_bresp2),
      .m_awvalid(m_awvalid2), .m_awready(m_awready), .m_awaddr(m_awaddr2),
      .m_wvalid(m_wvalid2), .m_wready(m_wready), .m_wdata(m_wdata2), .m_wstrb(m_wstrb2),
      .m_bvalid(m_bvalid), .m_bready(m_bready2), .m_bresp(m_bresp),
      .region_en(region_en), .viol_clr(viol_clr), .violation(violation2),
      .viol_addr(viol_addr2), .viol_count(viol_count2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Results of the last write_txn
   logic [31:0] r_maddr, r_mdata;
   logic [3:0]  r_mstrb;
   logic [1:0]  r_bresp;
   int          r_aw_hs, r_w_hs, r_viol, r_lat_m, r_lat_b;
   bit          r_done, r_busy_rdy, r_in_waitb;

   task automatic idle_inputs();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      viol_clr  = 1'b0;
   endtask

   // One upstream write, with the bench also playing the downstream slave.
   // Everything is sampled and driven at the falling edge.
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_at, input int w_at,
                            input int aw_rdy_dly, input logic [1:0] mresp,
                            input bit clr_on_viol, input bit abort_waitb);
      bit aw_done = 0, w_done = 0, s_done = 0;
      int aw_wait = 0, cap = -1, mfirst = -1, bhs = -1, sfirst = -1;
      r_aw_hs = 0; r_w_hs = 0; r_viol = 0; r_bresp = 2'bxx;
      r_busy_rdy = 0; r_in_waitb = 0;
      r_maddr = 'x; r_mdata = 'x; r_mstrb = 'x;
      for (int c = 0; c < 80 && !s_done; c++) begin
         @(negedge clk);
         viol_clr = 1'b0;
         if (violation) begin
            r_viol++;
            if (clr_on_viol) viol_clr = 1'b1;
         end
         s_awaddr  = addr;
         s_wdata   = data;
         s_wstrb   = strb;
         s_awvalid = (c >= aw_at) && !aw_done;
         s_wvalid  = (c >= w_at) && !w_done;
         if (s_awvalid && s_awready) aw_done = 1;
         if (s_wvalid && s_wready)   w_done  = 1;
         if (aw_done && w_done && cap < 0) cap = c + 1;

         if ((m_awvalid || m_wvalid || m_bready) && (s_awready || s_wready)) r_busy_rdy = 1;
         m_awready = 1'b0;
         if (m_awvalid) begin
            if (mfirst < 0) mfirst = c;
            m_awready = (aw_wait >= aw_rdy_dly);
            aw_wait++;
            if (m_awready) begin r_aw_hs++; r_maddr = m_awaddr; end
         end
         m_wready = m_wvalid;
         if (m_wvalid) begin
            if (mfirst < 0) mfirst = c;
            r_w_hs++; r_mdata = m_wdata; r_mstrb = m_wstrb;
         end

         m_bvalid = 1'b0;
         if (m_bready) begin
            r_in_waitb = 1;
            if (abort_waitb) begin
               rst_n  = 1'b0;
               s_done = 1;
            end else if (r_aw_hs > 0 && r_w_hs > 0) begin
               m_bvalid = 1'b1; m_bresp = mresp; bhs = c;
            end
         end

         s_bready = 1'b0;
         if (s_bvalid) begin
            if (sfirst < 0) sfirst = c;
            if (s_awready || s_wready) r_busy_rdy = 1;
            s_bready = (c >= sfirst + 1);
            if (s_bready) begin r_bresp = s_bresp; s_done = 1; end
         end
      end
      @(negedge clk);
      idle_inputs();
      r_done  = s_done;
      r_lat_m = (cap >= 0 && mfirst >= 0) ? mfirst - cap : -1;
      r_lat_b = (bhs >= 0 && sfirst >= 0) ? sfirst - bhs : -1;
   endtask

   task automatic pulse_clr();
      @(negedge clk); viol_clr = 1'b1;
      @(negedge clk); viol_clr = 1'b0;
   endtask

   initial begin
      idle_inputs();
      s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
      region_en = 4'b0000;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_awready", s_awready, 1);
      check("rst_wready", s_wready, 1);
      check("rst_bvalid", s_bvalid, 0);
      check("rst_m_valid", {m_awvalid, m_wvalid, m_bready}, 0);
      check("rst_violation", violation, 0);
      check("rst_count", viol_count, 0);
      check("rst_vaddr", viol_addr, 0);
      check("rst_bresp", s_bresp, 0);

      // Write into enabled region 0 is blocked
      region_en = 4'b0001;
      write_txn(32'h4000_0010, 32'h1111_1111, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      check("blk_done", r_done, 1);
      check("blk_no_maw", r_aw_hs, 0);
      check("blk_no_mw", r_w_hs, 0);
      check("blk_viol_pulse", r_viol, 1);
      check("blk_bresp", r_bresp, 2'b10);
      check("blk_count", viol_count, 1);
      check("blk_vaddr", viol_addr, 32'h4000_0010);
      check("blk_busy_ready", r_busy_rdy, 0);

      // Address above the region is forwarded unchanged
      write_txn(32'h4001_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      check("fwd_done", r_done, 1);
      check("fwd_maw", r_aw_hs, 1);
      check("fwd_mw", r_w_hs, 1);
      check("fwd_maddr", r_maddr, 32'h4001_0000);
      check("fwd_mdata", r_mdata, 32'hDEAD_BEEF);
      check("fwd_viol", r_viol, 0);
      check("fwd_bresp", r_bresp, 2'b00);
      check("fwd_count", viol_count, 1);
      check("fwd_lat_m", r_lat_m, 2);
      check("fwd_lat_b", r_lat_b, 1);
      check("fwd_busy_ready", r_busy_rdy, 0);

      // Inclusive bounds
      write_txn(32'h4000_0000, 32'h0, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      check("lo_maw", r_aw_hs, 0);
      check("lo_bresp", r_bresp, 2'b10);
      check("lo_count", viol_count, 2);
      write_txn(32'h4000_FFFF, 32'h0, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      check("hi_maw", r_aw_hs, 0);
      check("hi_bresp", r_bresp, 2'b10);
      check("hi_count", viol_count, 3);
      check("hi_vaddr", viol_addr, 32'h4000_FFFF);
      write_txn(32'h3FFF_FFFF, 32'h5, 4'hF, 0, 0, 0, 2'b01, 0, 0);
      check("below_maw", r_aw_hs, 1);
      check("below_bresp", r_bresp, 2'b01);
      check("below_count", viol_count, 3);

      // Region disabled: both bounds forwarded
      region_en = 4'b0000;
      write_txn(32'h4000_0000, 32'hA5A5_0000, 4'hF, 0, 0, 0, 2'b01, 0, 0);
      check("dis_lo_maw", r_aw_hs, 1);
      check("dis_lo_maddr", r_maddr, 32'h4000_0000);
      check("dis_lo_bresp", r_bresp, 2'b01);
      write_txn(32'h4000_FFFF, 32'hA5A5_FFFF, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      check("dis_hi_maw", r_aw_hs, 1);
      check("dis_hi_maddr", r_maddr, 32'h4000_FFFF);
      check("dis_hi_viol", r_viol, 0);
      check("dis_count", viol_count, 3);
      check("dut2_count3", viol_count2, 3);

      // W leads AW by 3 cycles, downstream AW ready held off 5 cycles
      region_en = 4'b0001;
      write_txn(32'h4002_0000, 32'h1234_5678, 4'b0101, 3, 0, 5, 2'b00, 0, 0);
      check("wlead_done", r_done, 1);
      check("wlead_maw", r_aw_hs, 1);
      check("wlead_mw", r_w_hs, 1);
      check("wlead_maddr", r_maddr, 32'h4002_0000);
      check("wlead_mdata", r_mdata, 32'h1234_5678);
      check("wlead_mstrb", r_mstrb, 4'b0101);
      check("wlead_bresp", r_bresp, 2'b00);
      check("wlead_lat_m", r_lat_m, 2);

      // Clear coincident with a block (region 1): block wins
      region_en = 4'b0010;
      write_txn(32'h4000_1234, 32'h0, 4'hF, 0, 0, 0, 2'b00, 1, 0);
      check("clrblk_viol", r_viol, 1);
      check("clrblk_bresp", r_bresp, 2'b10);
      check("clrblk_count", viol_count, 1);
      check("clrblk_vaddr", viol_addr, 32'h4000_1234);
      check("clrblk_count2", viol_count2, 1);
      pulse_clr();
      check("clr_count", viol_count, 0);
      check("clr_vaddr", viol_addr, 0);
      check("clr_count2", viol_count2, 0);

      // Five blocks: 16-bit counter reaches 5, 2-bit counter saturates at 3
      region_en = 4'b0001;
      for (int i = 0; i < 5; i++)
         write_txn(32'h4000_0100 + i, 32'h0, 4'hF, 0, 0, 0, 2'b00, 0, 0);
      check("sat_count16", viol_count, 5);
      check("sat_count2", viol_count2, 3);
      check("sat_vaddr", viol_addr, 32'h4000_0104);

      // Reset while waiting for the downstream response
      region_en = 4'b0000;
      write_txn(32'h4003_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 0, 1);
      check("abort_reached_waitb", r_in_waitb, 1);
      check("abort_bvalid", s_bvalid, 0);
      check("abort_m_bready", m_bready, 0);
      check("abort_count", viol_count, 0);
      check("abort_vaddr", viol_addr, 0);
      check("abort_bresp", s_bresp, 0);
      check("abort_count2", viol_count2, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_awready", s_awready, 1);
      check("abort_wready", s_wready, 1);
      check("abort_bvalid_after", s_bvalid, 0);

      // Normal operation resumes after the abort
      write_txn(32'h4004_0000, 32'h0BAD_F00D, 4'b1000, 0, 2, 1, 2'b00, 0, 0);
      check("post_done", r_done, 1);
      check("post_maw", r_aw_hs, 1);
      check("post_mdata", r_mdata, 32'h0BAD_F00D);
      check("post_mstrb", r_mstrb, 4'b1000);
      check("post_bresp", r_bresp, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
